keypad_scanner: RTL and testbench

Upstream front end for the keypad lock FSM. Scans a 4x4 active-low matrix keypad, synchronizes and debounces the row returns, encodes each accepted press into a 4-bit key code, and maintains the entered-digit count. Its `number` and `count` outputs feed the lock FSM's `number[3:0]` and `count[2:0]` inputs directly.

---
 rtl/keypad_pkg.sv | 34 +++
 rtl/keypad_sync.sv | 24 ++
 rtl/keypad_scanner.sv | 151 +++++++++++++++
 tb/tb_keypad_scanner.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, constants and key-map helper for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    RELEASE
  } scan_state_e;

  localparam logic [3:0] KEY_STAR  = 4'd14;
  localparam logic [3:0] KEY_HASH  = 4'd15;
  localparam logic [3:0] NUM_IDLE  = 4'hF;
  localparam logic [2:0] MAX_COUNT = 3'd4;

  // Column 3 holds A-D (10-13); row 3 holds *, 0, #.
  function automatic logic [3:0] key_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    code = '0;
    if (col_idx == 2'd3) begin
      code = 4'd10 + {2'b00, row_idx};
    end else if (row_idx != 2'd3) begin
      code = ({2'b00, row_idx} * 4'd3) + {2'b00, col_idx} + 4'd1;
    end else begin
      case (col_idx)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up row returns.
module keypad_sync (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_d,
  output logic [3:0] o_q
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column strobe, debounce, key encode, digit count.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  input  logic       clear,
  output logic [3:0] col_out,
  output logic [3:0] number,
  output logic       digit_valid,
  output logic [2:0] count,
  output logic       key_held
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  scan_state_e      r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_col, w_col_nxt;
  logic [3:0]       r_pat, w_pat_nxt;
  logic             r_held, w_held_nxt;
  logic [2:0]       r_count, w_count_nxt;

  logic [3:0]       w_rs;
  logic [3:0]       w_low;
  logic             w_single;
  logic [1:0]       w_row;
  logic [3:0]       w_code;
  logic             w_emit;

  keypad_sync u_sync (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_d     (row_in),
    .o_q     (w_rs)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SCAN;
      r_div   <= '0;
      r_cnt   <= '0;
      r_col   <= '0;
      r_pat   <= '1;
      r_held  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
      r_col   <= w_col_nxt;
      r_pat   <= w_pat_nxt;
      r_held  <= w_held_nxt;
      r_count <= w_count_nxt;
    end
  end

  // The captured pattern is stable through DEBOUNCE, so EMIT decodes from it.
  always_comb begin
    w_low    = ~r_pat;
    w_single = (w_low != '0) && ((w_low & (w_low - 4'd1)) == '0);
    w_row    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_low[i]) w_row = 2'(i);
    end
    w_code = key_code(w_row, r_col);
    w_emit = (r_state == EMIT) && w_single;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_cnt_nxt   = r_cnt;
    w_col_nxt   = r_col;
    w_pat_nxt   = r_pat;
    w_held_nxt  = r_held;
    case (r_state)
      SCAN: begin
        if (r_div == DIV_LAST) begin
          w_div_nxt = '0;
          if (w_rs != '1) begin
            w_pat_nxt   = w_rs;
            w_cnt_nxt   = '0;
            w_state_nxt = DEBOUNCE;
          end else begin
            w_col_nxt = r_col + 2'd1;
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      DEBOUNCE: begin
        if (w_rs != r_pat) begin
          w_div_nxt   = '0;
          w_state_nxt = SCAN;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = EMIT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      EMIT: begin
        w_held_nxt  = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = RELEASE;
      end
      RELEASE: begin
        if (w_rs != '1) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == DB_LAST) begin
          w_held_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_div_nxt   = '0;
          w_col_nxt   = r_col + 2'd1;
          w_state_nxt = SCAN;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = SCAN;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (clear) begin
      w_count_nxt = '0;
    end else if (w_emit) begin
      if (w_code == KEY_STAR) begin
        w_count_nxt = '0;
      end else if ((w_code <= 4'd9) && (r_count != MAX_COUNT)) begin
        w_count_nxt = r_count + 3'd1;
      end
    end
  end

  assign col_out     = ~(4'b0001 << r_col);
  assign number      = w_emit ? w_code : NUM_IDLE;
  assign digit_valid = w_emit;
  assign count       = r_count;
  assign key_held    = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized and directed bench for keypad_scanner against a key-level reference model.
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] row_in;
  logic       clear;
  logic [3:0] col_out;
  logic [3:0] number;
  logic       digit_valid;
  logic [2:0] count;
  logic       key_held;

  logic [3:0] pressed [4];
  int         keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  int n_total = 0;
  int n_bad   = 0;
  int exp_count = 0;
  int q_got [$];
  int q_cnt [$];
  bit prev_dv = 0;
  bit cnt_pending = 0;

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row_in      (row_in),
    .clear       (clear),
    .col_out     (col_out),
    .number      (number),
    .digit_valid (digit_valid),
    .count       (count),
    .key_held    (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical matrix: a row reads low when a pressed key sits in a driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_in[r] = ~|(pressed[r] & ~col_out);
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_count(input int cur, input int code, input bit clr);
    if (clr) return 0;
    if (code == 14) return 0;
    if (code <= 9) return (cur >= 4) ? 4 : cur + 1;
    return cur;
  endfunction

  always @(negedge clk) begin
    if (cnt_pending) begin
      q_cnt.push_back(int'(count));
      cnt_pending = 0;
    end
    if (digit_valid) begin
      check_eq("dv_consecutive", int'(prev_dv), 0);
      q_got.push_back(int'(number));
      cnt_pending = 1;
    end else begin
      check_eq("number_idle", int'(number), 15);
    end
    prev_dv = digit_valid;
  end

  task automatic release_all();
    for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
  endtask

  // Keys already down; hold, release, then score pulses and count against the model.
  task automatic finish_press(input int r, input int c, input int hold, input bit multi, input bit arm_clear);
    int k;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      clear = arm_clear && digit_valid;
    end
    @(negedge clk);
    clear = 1'b0;
    check_eq("held_while_pressed", int'(key_held), 1);
    release_all();
    repeat (4) @(negedge clk);
    check_eq("held_during_release_debounce", int'(key_held), 1);
    k = 0;
    while (key_held && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("held_drops_after_release", int'(key_held), 0);
    repeat (3) @(negedge clk);
    if (!multi) exp_count = model_count(exp_count, keymap[r][c], arm_clear);
    check_eq("pulse_count", q_got.size(), multi ? 0 : 1);
    if (!multi && q_got.size() > 0) check_eq("key_code", q_got[0], keymap[r][c]);
    if (q_cnt.size() > 0) check_eq("count_after_pulse", q_cnt[0], exp_count);
    check_eq("count_settled", int'(count), exp_count);
  endtask

  task automatic do_press(input int r, input int c, input int hold, input bit bounce,
                          input bit multi, input bit arm_clear);
    q_got.delete();
    q_cnt.delete();
    check_eq("held_idle", int'(key_held), 0);
    if (bounce) begin
      for (int i = 0; i < 20; i++) begin
        if (i % 3 == 0) pressed[r][c] = ~pressed[r][c];
        @(negedge clk);
      end
    end
    pressed[r][c] = 1'b1;
    if (multi) pressed[r+1][c] = 1'b1;
    finish_press(r, c, hold, multi, arm_clear);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_count = 0;
    @(negedge clk);
    check_eq("count_cleared", int'(count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    release_all();
    clear = 1'b0;
    rst   = 1'b1;
    #3 rst = 1'b0;
    #1;
    check_eq("rst_col_out", int'(col_out), 4'b1110);
    check_eq("rst_number", int'(number), 15);
    check_eq("rst_digit_valid", int'(digit_valid), 0);
    check_eq("rst_count", int'(count), 0);
    check_eq("rst_key_held", int'(key_held), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    do_press(0, 0, 30, 0, 0, 0);          // clean 1
    do_press(2, 0, 40, 1, 0, 0);          // bouncy 7
    pulse_clear();
    do_press(0, 0, 40, 0, 0, 0);          // 1,3,3,7,9
    do_press(0, 2, 40, 0, 0, 0);
    do_press(0, 2, 40, 0, 0, 0);
    do_press(2, 0, 40, 0, 0, 0);
    do_press(2, 2, 40, 0, 0, 0);
    pulse_clear();
    do_press(0, 1, 40, 0, 0, 0);          // 2
    do_press(2, 1, 40, 0, 0, 0);          // 8
    do_press(3, 0, 40, 0, 0, 0);          // *
    do_press(1, 1, 40, 0, 0, 1);          // 5 with clear on its emit
    do_press(1, 0, 40, 0, 0, 0);          // 4
    do_press(0, 1, 40, 0, 1, 0);          // rows 0+1 in col1

    // Reset while debouncing key 5 (col1), key stays held through reset.
    q_got.delete();
    q_cnt.delete();
    k = 0;
    while (col_out == 4'b1101 && k < 64) begin @(negedge clk); k++; end
    k = 0;
    while (col_out != 4'b1101 && k < 64) begin @(negedge clk); k++; end
    check_eq("col1_reached", int'(col_out), 4'b1101);
    pressed[1][1] = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("col_frozen_in_debounce", int'(col_out), 4'b1101);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_col_out", int'(col_out), 4'b1110);
    check_eq("mid_rst_number", int'(number), 15);
    check_eq("mid_rst_digit_valid", int'(digit_valid), 0);
    check_eq("mid_rst_count", int'(count), 0);
    check_eq("mid_rst_key_held", int'(key_held), 0);
    exp_count = 0;
    @(negedge clk);
    rst = 1'b1;
    finish_press(1, 1, 60, 0, 0);

    for (int n = 0; n < 16; n++) begin
      int rr, cc, hh;
      bit bb;
      rr = int'($urandom_range(0, 3));
      cc = int'($urandom_range(0, 3));
      hh = int'($urandom_range(40, 70));
      bb = ($urandom_range(0, 1) == 1);
      do_press(rr, cc, hh, bb, 0, 0);
      if ($urandom_range(0, 3) == 0) pulse_clear();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
